// File: rtl/alu_pkg.sv
// alu_pkg: ALU opcode constants and arbiter state type shared by the ALU arbiter.
package alu_pkg;
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SLL = 3'b101;
    typedef enum logic [1:0] {IDLE, EXEC, RESP} arb_state_t;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin grant; on a tie the requester not granted last wins.
module rr_arb2 (
    input  logic v0,
    input  logic v1,
    input  logic last,
    output logic g0,
    output logic g1
);
    assign g0 = v0 && (!v1 || last);
    assign g1 = v1 && (!v0 || !last);
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one registered ALU between two requesters, one operation per three cycles.
module alu_arbiter import alu_pkg::*; #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [XLEN-1:0] req0_in1,
    input  logic [XLEN-1:0] req0_in2,
    input  logic [2:0]      req0_op,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [XLEN-1:0] req1_in1,
    input  logic [XLEN-1:0] req1_in2,
    input  logic [2:0]      req1_op,
    output logic            resp0_valid,
    output logic            resp1_valid,
    output logic [XLEN-1:0] resp_out,
    output logic            resp_zero,
    output logic            resp_lt,
    output logic            resp_ltu,
    output logic [XLEN-1:0] alu_in1,
    output logic [XLEN-1:0] alu_in2,
    output logic [2:0]      alu_op,
    input  logic [XLEN-1:0] alu_out,
    input  logic            zero,
    input  logic            less_than,
    input  logic            less_than_unsigned
);
    arb_state_t state;
    logic owner, last, g0, g1, hs;
    rr_arb2 u_arb (.v0(req0_valid), .v1(req1_valid), .last(last), .g0(g0), .g1(g1));
    assign req0_ready  = state == IDLE && !reset && g0;
    assign req1_ready  = state == IDLE && !reset && g1;
    assign hs          = req0_ready || req1_ready;
    assign resp0_valid = state == RESP && !owner;
    assign resp1_valid = state == RESP && owner;
    // The ALU result registered during EXEC is presented directly while in RESP.
    assign resp_out    = alu_out;
    assign resp_zero   = zero;
    assign resp_lt     = less_than;
    assign resp_ltu    = less_than_unsigned;
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            alu_in1 <= '0;
            alu_in2 <= '0;
            alu_op  <= OP_ADD;
            owner   <= 1'b0;
            last    <= 1'b1;
        end else begin
            state <= state == EXEC ? RESP : (state == IDLE && hs) ? EXEC : IDLE;
            if (hs) begin
                alu_in1 <= req1_ready ? req1_in1 : req0_in1;
                alu_in2 <= req1_ready ? req1_in2 : req0_in2;
                alu_op  <= req1_ready ? req1_op : req0_op;
                owner   <= req1_ready;
                last    <= req1_ready;
            end
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed checks of the two-requester ALU arbiter against a registered ALU model.
module tb_alu_arbiter;
    logic        clk = 0, reset = 1;
    logic        req0_valid = 0, req1_valid = 0, req0_ready, req1_ready;
    logic [31:0] req0_in1 = 0, req0_in2 = 0, req1_in1 = 0, req1_in2 = 0;
    logic [2:0]  req0_op = 0, req1_op = 0;
    logic        resp0_valid, resp1_valid, resp_zero, resp_lt, resp_ltu;
    logic [31:0] resp_out, alu_in1, alu_in2, alu_out, r;
    logic [2:0]  alu_op;
    logic        zero, less_than, less_than_unsigned;
    int vectors = 0, miscompares = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.XLEN(32)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_in1(req0_in1), .req0_in2(req0_in2), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_in1(req1_in1), .req1_in2(req1_in2), .req1_op(req1_op),
        .resp0_valid(resp0_valid), .resp1_valid(resp1_valid), .resp_out(resp_out),
        .resp_zero(resp_zero), .resp_lt(resp_lt), .resp_ltu(resp_ltu),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op), .alu_out(alu_out),
        .zero(zero), .less_than(less_than), .less_than_unsigned(less_than_unsigned)
    );

    // Registered ALU model: one cycle from alu_* inputs to result.
    always_comb
        r = alu_op == 3'b000 ? alu_in1 + alu_in2 :
            alu_op == 3'b001 ? alu_in1 - alu_in2 :
            alu_op == 3'b010 ? alu_in1 & alu_in2 :
            alu_op == 3'b011 ? alu_in1 | alu_in2 :
            alu_op == 3'b101 ? alu_in1 << alu_in2[4:0] : 32'h0;
    always_ff @(posedge clk) begin
        alu_out            <= r;
        zero               <= r == 32'h0;
        less_than          <= $signed(alu_in1) < $signed(alu_in2);
        less_than_unsigned <= alu_in1 < alu_in2;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Starts in IDLE with requester n expected to win; runs handshake, EXEC, RESP, back to IDLE.
    task automatic op_cycle(input logic n, input logic [31:0] ea, input logic [31:0] eb, input logic [2:0] eop,
                            input logic [31:0] eout, input logic [2:0] eflags, input logic drop);
        #1;
        chk("ready_sel", n ? req1_ready : req0_ready, 1);
        chk("ready_other", n ? req0_ready : req1_ready, 0);
        tick();
        if (drop) begin
            if (n) req1_valid = 0;
            else req0_valid = 0;
        end
        chk("exec_ready", {req0_ready, req1_ready}, 0);
        chk("alu_in1", alu_in1, ea);
        chk("alu_in2", alu_in2, eb);
        chk("alu_op", alu_op, eop);
        chk("exec_resp", {resp0_valid, resp1_valid}, 0);
        tick();
        chk("resp_valid", {resp0_valid, resp1_valid}, n ? 2'b01 : 2'b10);
        chk("resp_out", resp_out, eout);
        chk("resp_flags", {resp_zero, resp_lt, resp_ltu}, eflags);
        tick();
        chk("idle_resp", {resp0_valid, resp1_valid}, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset with both valids asserted: nothing may be accepted.
        req0_valid = 1; req1_valid = 1;
        tick(); tick();
        chk("rst_ready", {req0_ready, req1_ready}, 0);
        chk("rst_alu", {alu_in1, alu_in2} == 64'h0, 1);
        chk("rst_op", alu_op, 0);
        chk("rst_resp", {resp0_valid, resp1_valid}, 0);
        req0_valid = 0; req1_valid = 0; reset = 0;
        tick();
        chk("idle_noreq", {req0_ready, req1_ready}, 0);

        // Single requester ADD.
        req0_valid = 1; req0_in1 = 10; req0_in2 = 20; req0_op = 3'b000;
        op_cycle(0, 10, 20, 3'b000, 32'd30, 3'b011, 1);

        // Tie straight out of reset: requester 0 first, then 1.
        reset = 1; tick(); reset = 0;
        req0_valid = 1; req0_in1 = 50; req0_in2 = 30; req0_op = 3'b001;
        req1_valid = 1; req1_in1 = 32'hFFFF0000; req1_in2 = 32'h0000FFFF; req1_op = 3'b010;
        op_cycle(0, 50, 30, 3'b001, 32'd20, 3'b000, 1);
        op_cycle(1, 32'hFFFF0000, 32'h0000FFFF, 3'b010, 32'h0, 3'b110, 1);

        // Both held valid: grants alternate every third cycle.
        req0_valid = 1; req0_in1 = 1; req0_in2 = 2; req0_op = 3'b000;
        req1_valid = 1; req1_in1 = 32'hF0; req1_in2 = 32'h0F; req1_op = 3'b011;
        for (int i = 0; i < 6; i++)
            if (i % 2 == 0) op_cycle(0, 1, 2, 3'b000, 32'd3, 3'b011, 0);
            else op_cycle(1, 32'hF0, 32'h0F, 3'b011, 32'hFF, 3'b000, 0);
        req0_valid = 0; req1_valid = 0;

        // Signed/unsigned compare and shift.
        req1_valid = 1; req1_in1 = 32'hFFFFFFFE; req1_in2 = 1; req1_op = 3'b001;
        op_cycle(1, 32'hFFFFFFFE, 1, 3'b001, 32'hFFFFFFFD, 3'b010, 1);
        req0_valid = 1; req0_in1 = 32'hF; req0_in2 = 2; req0_op = 3'b101;
        op_cycle(0, 32'hF, 2, 3'b101, 32'h3C, 3'b000, 1);

        // Reset during EXEC aborts the operation.
        req0_valid = 1; req0_in1 = 5; req0_in2 = 6; req0_op = 3'b001;
        #1;
        chk("abort_ready", req0_ready, 1);
        tick();
        chk("abort_exec_in1", alu_in1, 5);
        reset = 1;
        tick();
        chk("abort_alu", {alu_in1, alu_in2} == 64'h0, 1);
        chk("abort_op", alu_op, 0);
        chk("abort_ready_rst", {req0_ready, req1_ready}, 0);
        chk("abort_resp", {resp0_valid, resp1_valid}, 0);
        reset = 0; req0_valid = 0;
        tick();
        chk("abort_noresp", {resp0_valid, resp1_valid}, 0);
        req1_valid = 1; req1_in1 = 7; req1_in2 = 8; req1_op = 3'b000;
        op_cycle(1, 7, 8, 3'b000, 32'd15, 3'b011, 1);

        // Undefined opcode passes through; req0 arriving in RESP waits and uses its latest operands.
        req1_valid = 1; req1_in1 = 3; req1_in2 = 4; req1_op = 3'b111;
        #1;
        chk("late_ready1", req1_ready, 1);
        tick();
        req1_valid = 0;
        chk("undef_op", alu_op, 3'b111);
        tick();
        req0_valid = 1; req0_in1 = 1; req0_in2 = 1; req0_op = 3'b000;
        #1;
        chk("late_resp1", {resp0_valid, resp1_valid}, 2'b01);
        chk("late_undef_out", resp_out, 0);
        chk("late_ready0_resp", req0_ready, 0);
        req0_in1 = 100; req0_in2 = 23;
        tick();
        op_cycle(0, 100, 23, 3'b000, 32'd123, 3'b000, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
